// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, one stop bit.
// Define UART_TX_BUFFER_EN to add a one-entry holding register for back-to-back frames.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] PData,
  input  logic                  DataValid,
  input  logic                  ParityEn,
  input  logic                  ParityType,
  output logic                  TX_OUT,
  output logic                  Ready,
  output logic                  Busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    tx_q, tx_d;

  logic                    tick;
  logic                    accept;
  logic                    stop_end;
  logic                    launch;
  logic [DATA_WIDTH-1:0]   src_data;
  logic                    src_par_en;
  logic                    src_par_bit;
  logic                    in_par_bit;

  assign tick       = (presc_q == PRESC_MAX);
  assign accept     = DataValid & Ready;
  assign stop_end   = (state_q == S_STOP) && tick;
  assign in_par_bit = (^PData) ^ ParityType;

`ifdef UART_TX_BUFFER_EN
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_par_en_q;
  logic                  hold_par_bit_q;
  logic                  hold_vld_q;
  logic                  load_hold;
  logic                  drain;

  // A new frame starts from IDLE or straight out of STOP; a pending held byte has priority.
  assign Ready       = !hold_vld_q;
  assign launch      = ((state_q == S_IDLE) || stop_end) && (hold_vld_q || accept);
  assign drain       = launch && hold_vld_q;
  assign load_hold   = accept && !launch;
  assign src_data    = hold_vld_q ? hold_q         : PData;
  assign src_par_en  = hold_vld_q ? hold_par_en_q  : ParityEn;
  assign src_par_bit = hold_vld_q ? hold_par_bit_q : in_par_bit;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_q         <= '0;
      hold_par_en_q  <= 1'b0;
      hold_par_bit_q <= 1'b0;
      hold_vld_q     <= 1'b0;
    end else if (load_hold) begin
      hold_q         <= PData;
      hold_par_en_q  <= ParityEn;
      hold_par_bit_q <= in_par_bit;
      hold_vld_q     <= 1'b1;
    end else if (drain) begin
      hold_vld_q     <= 1'b0;
    end
  end
`else
  assign Ready       = (state_q == S_IDLE);
  assign launch      = accept;
  assign src_data    = PData;
  assign src_par_en  = ParityEn;
  assign src_par_bit = in_par_bit;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    if (state_q != S_IDLE) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = launch ? S_START : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (launch) begin
      shift_d   = src_data;
      par_en_d  = src_par_en;
      par_bit_d = src_par_bit;
      presc_d   = '0;
      bit_d     = '0;
    end
  end

  // Line level is decoded from the next state so TX_OUT stays aligned with the state register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a frame-decoding line monitor.
module tb_uart_tx;

  localparam int P  = 8;
  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] PData;
  logic          DataValid;
  logic          ParityEn;
  logic          ParityType;
  logic          TX_OUT;
  logic          Ready;
  logic          Busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [DW-1:0] data;
    bit            pe;
    bit            pt;
  } item_t;

  item_t exp_q[$];
  int    starts_q[$];
  bit    mon_en   = 1'b1;
  bit    mon_busy = 1'b0;

  uart_tx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PData      (PData),
    .DataValid  (DataValid),
    .ParityEn   (ParityEn),
    .ParityType (ParityType),
    .TX_OUT     (TX_OUT),
    .Ready      (Ready),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Line monitor: decodes each frame bit by bit and compares against the oldest expected item.
  initial begin : monitor
    item_t e;
    int    nbits;
    bit    exp_bits[12];
    bit    first;
    bit    stable;
    bit    busy_ok;
    forever begin
      @(negedge CLK);
      if (mon_en && RST && TX_OUT === 1'b0) begin
        mon_busy = 1'b1;
        starts_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("frame_expected", 0, 1);
          e = '{data: '0, pe: 1'b0, pt: 1'b0};
        end else begin
          e = exp_q.pop_front();
        end
        nbits = DW + 2 + int'(e.pe);
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) exp_bits[1+i] = e.data[i];
        if (e.pe) exp_bits[DW+1] = ($countones(e.data) % 2 == 1) ^ e.pt;
        exp_bits[nbits-1] = 1'b1;
        busy_ok = 1'b1;
        for (int b = 0; b < nbits; b++) begin
          stable = 1'b1;
          first  = 1'b0;
          for (int c = 0; c < P; c++) begin
            if (b != 0 || c != 0) @(negedge CLK);
            if (Busy !== 1'b1) busy_ok = 1'b0;
            if (c == 0) first = TX_OUT;
            else if (TX_OUT !== first) stable = 1'b0;
          end
          chk($sformatf("frame_bit%0d_data%02h", b, e.data), int'(first), int'(exp_bits[b]));
          chk($sformatf("bit_width%0d", b), int'(stable), 1);
        end
        chk("busy_during_frame", int'(busy_ok), 1);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge CLK);
    while (Ready !== 1'b1 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt, input bit push);
    wait_ready();
    PData      = d;
    ParityEn   = pe;
    ParityType = pt;
    DataValid  = 1'b1;
    @(posedge CLK);
    if (push) exp_q.push_back('{data: d, pe: pe, pt: pt});
    #1;
    DataValid  = 1'b0;
    PData      = DW'($urandom);
    ParityEn   = 1'($urandom);
    ParityType = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy || Busy) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 0, 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic busy_len(input string nm, input int exp);
    int cnt;
    cnt = 0;
    @(negedge CLK);
    chk({nm, "_tx_start"}, int'(TX_OUT), 0);
    chk({nm, "_busy_start"}, int'(Busy), 1);
    while (Busy === 1'b1 && cnt < 500) begin
      cnt++;
      @(negedge CLK);
    end
    chk({nm, "_busy_len"}, cnt, exp);
  endtask

  initial begin : stim
    int lows;
    int gap_exp;
    RST = 1'b0; DataValid = 1'b0; PData = '0; ParityEn = 1'b0; ParityType = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tx", int'(TX_OUT), 1);
    chk("rst_ready", int'(Ready), 1);
    chk("rst_busy", int'(Busy), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_tx", int'(TX_OUT), 1);
    chk("idle_ready", int'(Ready), 1);

    send(8'hA5, 1'b0, 1'b0, 1'b1);
    busy_len("a5_np", 80);
    drain();
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    busy_len("a5_even", 88);
    drain();
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    drain();
    send(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    ParityType = 1'b1;
    PData      = 8'hFF;
    ParityEn   = 1'b0;
    drain();

    // Back-to-back with DataValid held high.
    starts_q.delete();
    wait_ready();
    PData = 8'h11; ParityEn = 1'b0; ParityType = 1'b0; DataValid = 1'b1;
    @(posedge CLK);
    exp_q.push_back('{data: 8'h11, pe: 1'b0, pt: 1'b0});
    @(negedge CLK);
    PData = 8'h22;
    wait_ready();
    @(posedge CLK);
    exp_q.push_back('{data: 8'h22, pe: 1'b0, pt: 1'b0});
    #1 DataValid = 1'b0;
    drain();
`ifdef UART_TX_BUFFER_EN
    gap_exp = 80;
`else
    gap_exp = 81;
`endif
    chk("b2b_frames", starts_q.size(), 2);
    if (starts_q.size() >= 2) chk("b2b_start_spacing", starts_q[1] - starts_q[0], gap_exp);

    // Asynchronous reset in the middle of a frame.
    mon_en = 1'b0;
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge CLK);
    chk("midframe_tx_low", int'(TX_OUT), 0);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_tx", int'(TX_OUT), 1);
    chk("async_rst_busy", int'(Busy), 0);
    chk("async_rst_ready", int'(Ready), 1);
    @(negedge CLK);
    RST = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) lows++;
    end
    chk("no_resume_after_rst", lows, 0);
    mon_en = 1'b1;

    // Randomized traffic with random idle gaps.
    for (int i = 0; i < 24; i++) begin
      send(DW'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: accepts a parallel byte over a valid/ready handshake and serialises it as start bit, data bits LSB first, optional parity bit and one stop bit on TX_OUT. It is the transmit-side counterpart of the UART receiver and shares its clock, its runtime parity controls and its oversampling ratio. Each line bit is held for PRESCALE CLK cycles, so a uart_tx/receiver pair on the same CLK interoperate directly.

## Interface
- DATA_WIDTH, 8: payload bits per frame.
- PRESCALE, 8: CLK cycles per line bit. Legal values are 2 or more; it must equal the receiver's oversampling ratio.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- PData  input  DATA_WIDTH  byte to transmit; sampled on accept.
- DataValid  input  1  transfer request; a byte is accepted when DataValid and Ready are both high at a CLK edge.
- ParityEn  input  1  1 adds a parity bit to the frame; sampled on accept.
- ParityType  input  1  0 selects even parity, 1 selects odd; sampled on accept.
- TX_OUT  output  1  serial line, registered, idles high.
- Ready  output  1  the block can accept a byte this cycle.
- Busy  output  1  a frame is in progress (state is not IDLE).

## Operation
- Accepted byte fields: PData, ParityEn and ParityType are captured together. Input changes after accept do not affect the frame in flight.
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE -> START on accept.
- START -> DATA after PRESCALE cycles.
- DATA -> PARITY or STOP after DATA_WIDTH bits. Goes to PARITY when the captured ParityEn is 1, otherwise to STOP.
- PARITY -> STOP after PRESCALE cycles.
- STOP -> IDLE, or STOP -> START when a buffered byte is pending (see Configuration).
- Line levels by state: START drives 0, DATA drives shift-register bit 0 (register shifts right once per bit), PARITY drives the parity bit, STOP and IDLE drive 1.
- Parity bit: XOR of the captured data bits, inverted when ParityType is 1.
- Prescale counter: width is clog2(PRESCALE). It counts 0..PRESCALE-1 and wraps, and the bit advances on the wrap. The bit counter width is clog2(DATA_WIDTH+1).
- DataValid while Ready is low: the request is ignored. No data is lost from the frame in flight, and the caller must hold DataValid until it sees Ready.
- Reset, whether idle or mid-frame, forces immediately: TX_OUT=1, Busy=0, Ready=1, state IDLE, all counters 0, buffer empty. No partial frame resumes after reset.

## Timing
- Reset values: TX_OUT=1, Ready=1, Busy=0.
- Accept at edge n: TX_OUT=0 and Busy=1 from edge n+1.
- Frame length: (DATA_WIDTH+2+ParityEn)*PRESCALE cycles, with every bit exactly PRESCALE cycles wide.
- Busy falls on the edge after the last STOP cycle. With the buffer compiled out, Ready=!Busy, which gives a minimum of 1 idle cycle between frames.
- Ready is a registered or state-decoded signal with no combinational path from DataValid.

## Configuration
- UART_TX_BUFFER_EN defined:
  - A one-entry holding register is added, and Ready = holding register empty.
  - A byte may be accepted during a frame. At the end of STOP with the holding register full, the FSM goes straight to START, so frames are back-to-back with zero idle cycles and Busy stays high.
  - When the holding register is loaded and drained on the same edge, the result is loaded.
- Not defined:
  - No holding register, Ready=!Busy, and accept happens only in IDLE.

## Test plan
- Reset then idle, PRESCALE=8: TX_OUT=1, Ready=1, Busy=0. Assert RST low mid-frame and TX_OUT returns to 1 with no clock edge.
- PData=0xA5, ParityEn=0: TX_OUT gives 0, then 1,0,1,0,0,1,0,1, then 1, each level held 8 cycles. Busy is high exactly 80 cycles.
- PData=0xA5, ParityEn=1, ParityType=0: the parity bit is 0 and the frame is 88 cycles. With ParityType=1 the parity bit is 1.
- PData=0x07, ParityEn=1, ParityType=0: the parity bit is 1. Change ParityType and PData mid-frame and the frame is unchanged.
- Hold DataValid high with 0x11 then 0x22:
  - Without UART_TX_BUFFER_EN: exactly 1 idle-high cycle between the frames.
  - With UART_TX_BUFFER_EN: the second start bit begins on the edge after the first stop bit ends.
- Loopback into the receiver, PRESCALE=8, parity on: 16 random bytes give PData matching and DataValid pulsing once per byte.
